uart_alu_if: RTL

//  Consumer stage downstream of the UART receiver; upstream of the UART transmitter.

---
 rtl/uart_alu_if_pkg.sv | 24 ++
 rtl/uart_alu_if_if.sv | 29 ++
 rtl/uart_alu_if_byte_timeout_timer.sv | 31 +++
 rtl/uart_alu_if.sv | 97 +++++++++
 4 files changed

// File: rtl/uart_alu_if_pkg.sv
// rtl/uart_alu_if_pkg.sv - shared widths, FSM states and ALU opcodes for the UART ALU path
package uart_alu_if_pkg;

   localparam int NB_DATA = 8;
   localparam int NB_OP   = 6;

   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      SEND    = 3'd3,
      WAIT_TX = 3'd4
   } state_t;

   localparam logic [NB_OP-1:0] OP_ADD = 6'h20;
   localparam logic [NB_OP-1:0] OP_SUB = 6'h22;
   localparam logic [NB_OP-1:0] OP_AND = 6'h24;
   localparam logic [NB_OP-1:0] OP_OR  = 6'h25;
   localparam logic [NB_OP-1:0] OP_XOR = 6'h26;
   localparam logic [NB_OP-1:0] OP_NOR = 6'h27;
   localparam logic [NB_OP-1:0] OP_SRL = 6'h02;
   localparam logic [NB_OP-1:0] OP_SRA = 6'h03;

endpackage

// File: rtl/uart_alu_if_if.sv
// rtl/uart_alu_if_if.sv - receiver/ALU/transmitter handshake bundle
interface uart_alu_if_if;
   import uart_alu_if_pkg::*;

   logic               rx_done_tick;
   logic [NB_DATA-1:0] rx_data;
   logic [NB_DATA-1:0] alu_result;
   logic               tx_done_tick;
   logic [NB_DATA-1:0] alu_a;
   logic [NB_DATA-1:0] alu_b;
   logic [NB_OP-1:0]   alu_op;
   logic               tx_start;
   logic [NB_DATA-1:0] tx_data;
   logic               busy;
   logic               rx_drop;

   // Frame assembler side
   modport slave (
      input  rx_done_tick, rx_data, alu_result, tx_done_tick,
      output alu_a, alu_b, alu_op, tx_start, tx_data, busy, rx_drop
   );

   // Receiver / ALU / transmitter side
   modport master (
      output rx_done_tick, rx_data, alu_result, tx_done_tick,
      input  alu_a, alu_b, alu_op, tx_start, tx_data, busy, rx_drop
   );

endinterface

// File: rtl/uart_alu_if_byte_timeout_timer.sv
// rtl/uart_alu_if_byte_timeout_timer.sv - saturating inter-byte gap counter
module byte_timeout_timer #(
   parameter int TIMEOUT_CYC = 10_000_000,
   parameter int NB_TO       = 24
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic expired
);

   // Last count value before the frame is abandoned; unused when the timeout is disabled
   localparam logic [NB_TO-1:0] LAST = (TIMEOUT_CYC > 0) ? NB_TO'(TIMEOUT_CYC - 1) : '0;

   logic [NB_TO-1:0] count;

   // Count gap cycles while enabled; stick at all-ones rather than wrap
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + NB_TO'(1);
      end
   end

   assign expired = (TIMEOUT_CYC > 0) && en && (count == LAST);

endmodule

// File: rtl/uart_alu_if.sv
// rtl/uart_alu_if.sv - assembles A, B, opcode bytes and returns the ALU result byte
module uart_alu_if
   import uart_alu_if_pkg::*;
#(
   parameter int TIMEOUT_CYC = 10_000_000,
   parameter int NB_TO       = 24
) (
   input logic          clk,
   input logic          reset,
   uart_alu_if_if.slave bus
);

   state_t state;
   logic   to_en;
   logic   to_clear;
   logic   to_expired;

   // The gap timer only runs while a frame is partially assembled; any byte restarts it
   assign to_en    = (state == WAIT_B) || (state == WAIT_OP);
   assign to_clear = !to_en || bus.rx_done_tick;

   byte_timeout_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .NB_TO       (NB_TO)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (to_clear),
      .en      (to_en),
      .expired (to_expired)
   );

   assign bus.busy = (state == SEND) || (state == WAIT_TX);

   // Frame FSM with operand, transmit and drop-flag registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= WAIT_A;
         bus.alu_a   <= '0;
         bus.alu_b   <= '0;
         bus.alu_op  <= '0;
         bus.tx_start <= 1'b0;
         bus.tx_data <= '0;
         bus.rx_drop <= 1'b0;
      end else begin
         case (state)
            WAIT_A: begin
               if (bus.rx_done_tick) begin
                  bus.alu_a <= bus.rx_data;
                  state     <= WAIT_B;
               end
            end
            WAIT_B: begin
               // A byte arriving on the expiry cycle still counts
               if (bus.rx_done_tick) begin
                  bus.alu_b <= bus.rx_data;
                  state     <= WAIT_OP;
               end else if (to_expired) begin
                  bus.rx_drop <= 1'b1;
                  state       <= WAIT_A;
               end
            end
            WAIT_OP: begin
               if (bus.rx_done_tick) begin
                  bus.alu_op <= bus.rx_data[NB_OP-1:0];
                  state      <= SEND;
               end else if (to_expired) begin
                  bus.rx_drop <= 1'b1;
                  state       <= WAIT_A;
               end
            end
            SEND: begin
               bus.tx_data  <= bus.alu_result;
               bus.tx_start <= 1'b1;
               if (bus.rx_done_tick) begin
                  bus.rx_drop <= 1'b1;
               end
               state <= WAIT_TX;
            end
            WAIT_TX: begin
               bus.tx_start <= 1'b0;
               if (bus.rx_done_tick) begin
                  bus.rx_drop <= 1'b1;
               end
               if (bus.tx_done_tick) begin
                  state <= WAIT_A;
               end
            end
            default: begin
               bus.tx_start <= 1'b0;
               state        <= WAIT_A;
            end
         endcase
      end
   end

endmodule
